// File: rtl/demux14_pkg.sv
// Shared types and sizes for the 4:1 TDM demultiplexer.
package demux14_pkg;
  typedef enum logic {HUNT, RUN} state_e;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int FCNT_W    = 8;
endpackage

// File: rtl/demux14_slot_ctr.sv
// Slot index counter: clear on disable, resync to slot 1 on an accepted frame_sync, advance on data.
// Latency: slot updates at the edge sampling the control; stalls hold when no control is asserted.
module demux14_slot_ctr
  import demux14_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              set1,
  input  logic              adv,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slot <= '0;
    else if (clr)
      slot <= '0;
    else if (set1)
      slot <= SLOT_W'(1);
    else if (adv)
      slot <= slot + 1'b1;  // wraps 3 -> 0 at the end of a frame
  end

endmodule

// File: rtl/demux14_tdm.sv
// 1:4 TDM demultiplexer with frame_sync alignment; optional sync_err under DEMUX14_SYNC_ERR_EN.
// Latency: q0..q3/word_vld one clock after the slot-3 sample; din_vld low stalls (no backpressure).
module demux14_tdm
  import demux14_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_vld,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  q0,
  output logic [WIDTH-1:0]  q1,
  output logic [WIDTH-1:0]  q2,
  output logic [WIDTH-1:0]  q3,
  output logic              word_vld,
  output logic [SLOT_W-1:0] slot,
  output logic [FCNT_W-1:0] frame_cnt
`ifdef DEMUX14_SYNC_ERR_EN
  ,
  output logic              sync_err
`endif
);

  state_e           state, state_nxt;
  logic             accept, run, set1, adv, last;
  logic [WIDTH-1:0] shadow [NUM_SLOTS-1];

  assign accept = en & din_vld;
  assign run    = (state == RUN);
  assign set1   = accept & frame_sync;
  assign adv    = run & accept & ~frame_sync;
  assign last   = adv & (slot == SLOT_W'(NUM_SLOTS - 1));

  demux14_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~en),
    .set1  (set1),
    .adv   (adv),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= HUNT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (set1) state_nxt = RUN;
      RUN:  if (!en)  state_nxt = HUNT;
    endcase
  end

  // Slot 3 never lands in the shadow: it is forwarded straight into q3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
    end else if (!en) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
    end else if (set1) begin
      shadow[0] <= din;
    end else if (adv) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++)
        if (slot == SLOT_W'(i)) shadow[i] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0        <= '0;
      q1        <= '0;
      q2        <= '0;
      q3        <= '0;
      word_vld  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      word_vld <= last;
      if (last) begin
        q0        <= shadow[0];
        q1        <= shadow[1];
        q2        <= shadow[2];
        q3        <= din;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

`ifdef DEMUX14_SYNC_ERR_EN
  // Misalignment: sync arriving mid-frame, or a frame boundary passing without sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync_err <= 1'b0;
    else
      sync_err <= run & accept & (frame_sync ? (slot != '0) : (slot == '0));
  end
`endif

endmodule

// File: tb/tb_demux14_tdm.sv
// Randomized and directed bench for demux14_tdm against a frame-level queue model.
module tb_demux14_tdm;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] din;
  logic         din_vld;
  logic         frame_sync;
  logic [W-1:0] q0, q1, q2, q3;
  logic         word_vld;
  logic [1:0]   slot;
  logic [7:0]   frame_cnt;
`ifdef DEMUX14_SYNC_ERR_EN
  logic         sync_err;
`endif

  int checks = 0;
  int errors = 0;

  // Model: locked flag plus the samples collected so far in the current frame.
  bit           locked;
  logic [W-1:0] part[$];
  logic [W-1:0] exp_q[4];
  bit           exp_wv;
  int           exp_fc;
  bit           exp_se;

  demux14_tdm #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .din_vld    (din_vld),
    .frame_sync (frame_sync),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .word_vld   (word_vld),
    .slot       (slot),
    .frame_cnt  (frame_cnt)
`ifdef DEMUX14_SYNC_ERR_EN
    ,
    .sync_err   (sync_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    locked = 0;
    part.delete();
    for (int i = 0; i < 4; i++) exp_q[i] = '0;
    exp_wv = 0;
    exp_fc = 0;
    exp_se = 0;
  endtask

  task automatic model_edge(input bit e, input logic [W-1:0] d, input bit v, input bit fs);
    exp_wv = 0;
    exp_se = 0;
    if (!e) begin
      locked = 0;
      part.delete();
    end else if (v) begin
      if (!locked) begin
        if (fs) begin
          locked = 1;
          part.delete();
          part.push_back(d);
        end
      end else if (fs) begin
        exp_se = (part.size() != 0);
        part.delete();
        part.push_back(d);
      end else begin
        exp_se = (part.size() == 0);
        part.push_back(d);
        if (part.size() == 4) begin
          for (int i = 0; i < 4; i++) exp_q[i] = part[i];
          exp_wv = 1;
          exp_fc = (exp_fc + 1) % 256;
          part.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    check("q0", int'(q0), int'(exp_q[0]));
    check("q1", int'(q1), int'(exp_q[1]));
    check("q2", int'(q2), int'(exp_q[2]));
    check("q3", int'(q3), int'(exp_q[3]));
    check("word_vld", int'(word_vld), int'(exp_wv));
    check("slot", int'(slot), part.size());
    check("frame_cnt", int'(frame_cnt), exp_fc);
`ifdef DEMUX14_SYNC_ERR_EN
    check("sync_err", int'(sync_err), int'(exp_se));
`endif
  endtask

  task automatic step(input bit e, input logic [W-1:0] d, input bit v, input bit fs);
    @(negedge clk);
    en = e; din = d; din_vld = v; frame_sync = fs;
    @(posedge clk);
    model_edge(e, d, v, fs);
    #1 check_all();
  endtask

  task automatic frame(input logic [W-1:0] a, b, c, d);
    step(1, a, 1, 1);
    step(1, b, 1, 0);
    step(1, c, 1, 0);
    step(1, d, 1, 0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = '0; din_vld = 1'b0; frame_sync = 1'b0;
    model_reset();
    #3 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Unsynchronized samples in HUNT are ignored.
    step(1, 4'h7, 1, 0);
    step(1, 4'h3, 0, 1);
    frame(4'h0, 4'h1, 4'h0, 4'h1);
    step(1, 4'h0, 0, 0);

    // Stall between slots 1 and 2.
    step(1, 4'h1, 1, 1);
    step(1, 4'h0, 1, 0);
    step(1, 4'hF, 0, 0);
    step(1, 4'hE, 0, 1);
    step(1, 4'h1, 1, 0);
    step(1, 4'h0, 1, 0);

    // Missing sync at slot 0 keeps the frame going.
    step(1, 4'h9, 1, 0);
    step(1, 4'h8, 1, 0);
    step(1, 4'h7, 1, 0);
    step(1, 4'h6, 1, 0);

    // Resync at slot 2 drops the partial frame.
    step(1, 4'hA, 1, 1);
    step(1, 4'hB, 1, 0);
    frame(4'h1, 4'h0, 4'h1, 4'h0);

    // Asynchronous reset mid-frame at slot 2.
    step(1, 4'h5, 1, 1);
    step(1, 4'h6, 1, 0);
    async_reset();
    step(1, 4'h2, 1, 0);
    step(1, 4'h3, 1, 0);

    // 256 back-to-back frames wrap the frame counter.
    for (int f = 0; f < 256; f++)
      frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    check("fcnt_wrap", int'(frame_cnt), 0);

    // Disable at slot 1: back to HUNT, q and frame_cnt held.
    step(1, 4'hC, 1, 1);
    step(0, 4'hD, 1, 0);
    step(1, 4'hD, 1, 0);

    // Random traffic, mostly enabled, occasional misplaced syncs.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 24) != 0, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0);
      if (n == 1500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
